// File: rtl/bldc_hall_model_if.sv
// Commutation link between a BLDC controller and the motor/hall model.
// The controller (master) drives the phase selects and duty; the motor (slave) returns halls and status.
interface bldc_hall_model_if;
    logic [1:0]  selGrn;
    logic [1:0]  selYlw;
    logic [1:0]  selBlu;
    logic [10:0] duty;
    logic        hallGrn;
    logic        hallYlw;
    logic        hallBlu;
    logic [15:0] omega;
    logic [7:0]  rev_cnt;

    modport master (
        output selGrn, selYlw, selBlu, duty,
        input  hallGrn, hallYlw, hallBlu, omega, rev_cnt
    );

    modport slave (
        input  selGrn, selYlw, selBlu, duty,
        output hallGrn, hallYlw, hallBlu, omega, rev_cnt
    );
endinterface

// File: rtl/bldc_hall_model.sv
// BLDC motor + hall-sensor stand-in: integrates speed from the drive pattern and duty,
// integrates angle from speed, and steps the hall code one 60-degree sector per angle overflow.
module bldc_hall_model #(
    parameter int TICK_DIV       = 16,
    parameter int ACCEL_SHIFT    = 2,
    parameter int FRICTION_SHIFT = 8,
    parameter int BRAKE_DECEL    = 64,
    parameter int POS_W          = 20
) (
    input  logic          clk,
    input  logic          rst,
    bldc_hall_model_if.slave bus
);

    if (POS_W < 17) begin : g_pos_w_check
        $error("POS_W must be at least 17");
    end

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    // Hall code {Grn,Ylw,Blu} is the state encoding itself.
    typedef enum logic [2:0] {
        SEC_101 = 3'b101,
        SEC_100 = 3'b100,
        SEC_110 = 3'b110,
        SEC_010 = 3'b010,
        SEC_011 = 3'b011,
        SEC_001 = 3'b001
    } sector_t;

    typedef enum logic [1:0] {
        MODE_COAST,
        MODE_DRIVE,
        MODE_BRAKE
    } mode_t;

    sector_t          r_sector;
    sector_t          w_sector_nxt;
    logic [CNT_W-1:0] r_tick_cnt;
    logic [15:0]      r_omega;
    logic [POS_W-1:0] r_pos;
    logic [7:0]       r_rev_cnt;

    logic             w_tick;
    logic [5:0]       w_sel;
    logic [5:0]       w_exp_sel;
    mode_t            w_mode;
    logic [10:0]      w_duty_diff;
    logic [9:0]       w_excess;
    logic [18:0]      w_omega_ext;
    logic [18:0]      w_accel;
    logic [18:0]      w_friction;
    logic [18:0]      w_omega_raw;
    logic [15:0]      w_omega_sat;
    logic [POS_W:0]   w_pos_sum;
    logic             w_carry;

    assign w_tick = (r_tick_cnt == CNT_W'(TICK_DIV - 1));
    assign w_sel  = {bus.selGrn, bus.selYlw, bus.selBlu};

    always_comb begin
        w_exp_sel = 6'b00_00_00;
        case (r_sector)
            SEC_101: w_exp_sel = 6'b01_10_00;
            SEC_100: w_exp_sel = 6'b01_00_10;
            SEC_110: w_exp_sel = 6'b00_01_10;
            SEC_010: w_exp_sel = 6'b10_01_00;
            SEC_011: w_exp_sel = 6'b10_00_01;
            SEC_001: w_exp_sel = 6'b00_10_01;
            default: w_exp_sel = 6'b00_00_00;
        endcase
    end

    always_comb begin
        w_mode = MODE_COAST;
        if (w_sel == 6'b11_11_11) begin
            w_mode = MODE_BRAKE;
        end else if (w_sel == w_exp_sel) begin
            w_mode = MODE_DRIVE;
        end
    end

    assign w_duty_diff = bus.duty - 11'h400;
    assign w_excess    = (bus.duty > 11'h400) ? w_duty_diff[9:0] : 10'd0;

    // Speed math is done 19 bits wide; bit 18 set means the result went negative.
    assign w_omega_ext = {3'b000, r_omega};
    assign w_accel     = {9'd0, w_excess >> ACCEL_SHIFT};
    assign w_friction  = {3'b000, r_omega >> FRICTION_SHIFT};

    always_comb begin
        w_omega_raw = w_omega_ext;
        case (w_mode)
            MODE_DRIVE: w_omega_raw = w_omega_ext + w_accel - w_friction;
            MODE_BRAKE: w_omega_raw = w_omega_ext - 19'(BRAKE_DECEL);
            default:    w_omega_raw = w_omega_ext - w_friction;
        endcase
    end

    always_comb begin
        w_omega_sat = w_omega_raw[15:0];
        if (w_omega_raw[18]) begin
            w_omega_sat = 16'h0000;
        end else if (|w_omega_raw[17:16]) begin
            w_omega_sat = 16'hFFFF;
        end
    end

    assign w_pos_sum = {1'b0, r_pos} + {{(POS_W - 15){1'b0}}, r_omega};
    assign w_carry   = w_pos_sum[POS_W];

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_sector_nxt = r_sector;
        if (w_carry) begin
            case (r_sector)
                SEC_101: w_sector_nxt = SEC_100;
                SEC_100: w_sector_nxt = SEC_110;
                SEC_110: w_sector_nxt = SEC_010;
                SEC_010: w_sector_nxt = SEC_011;
                SEC_011: w_sector_nxt = SEC_001;
                SEC_001: w_sector_nxt = SEC_101;
                default: w_sector_nxt = SEC_101;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sector   <= SEC_101;
            r_tick_cnt <= '0;
            r_omega    <= 16'h0000;
            r_pos      <= '0;
            r_rev_cnt  <= 8'h00;
        end else begin
            r_sector <= w_sector_nxt;
            r_pos    <= w_pos_sum[POS_W-1:0];
            if (w_tick) begin
                r_tick_cnt <= '0;
                r_omega    <= w_omega_sat;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end
            if (w_carry && (r_sector == SEC_001)) begin
                r_rev_cnt <= r_rev_cnt + 8'h01;
            end
        end
    end

    assign bus.hallGrn = r_sector[2];
    assign bus.hallYlw = r_sector[1];
    assign bus.hallBlu = r_sector[0];
    assign bus.omega   = r_omega;
    assign bus.rev_cnt = r_rev_cnt;

endmodule
